// File: rtl/motor_drive_seq.sv
// Drive sequencer for the brushless commutation block: soft-ramps drv_mag toward
// target_mag, applies a timed brake on enable drop, and latches a stall fault.
module motor_drive_seq #(
  parameter int RAMP_STEP     = 16,
  parameter int RAMP_DIV      = 4,
  parameter int STALL_CYCLES  = 100,
  parameter int STALL_MIN_MAG = 64,
  parameter int BRAKE_CYCLES  = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [11:0] target_mag,
  input  logic        hallGrn,
  input  logic        hallYlw,
  input  logic        hallBlu,
  input  logic        clr_fault,
  output logic [11:0] drv_mag,
  output logic        brake_n,
  output logic        running,
  output logic        stall_fault
);

  localparam int DIV_W   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);
  localparam int BRK_W   = (BRAKE_CYCLES > 1) ? $clog2(BRAKE_CYCLES) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST    = DIV_W'(RAMP_DIV - 1);
  localparam logic [DIV_W-1:0]   DIV_ONE     = DIV_W'(1);
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(STALL_CYCLES);
  localparam logic [STALL_W-1:0] STALL_ONE   = STALL_W'(1);
  localparam logic [BRK_W-1:0]   BRK_LAST    = BRK_W'(BRAKE_CYCLES - 1);
  localparam logic [BRK_W-1:0]   BRK_ONE     = BRK_W'(1);
  localparam logic [11:0]        STEP        = 12'(RAMP_STEP);
  localparam logic [11:0]        MIN_MAG     = 12'(STALL_MIN_MAG);

  typedef enum logic [2:0] {IDLE, RAMP, RUN, BRAKE, FAULT} state_t;

  state_t             state, state_n;
  logic [11:0]        mag_n;
  logic [DIV_W-1:0]   div_cnt, div_n;
  logic [STALL_W-1:0] stall_cnt, stall_n, stall_run;
  logic [BRK_W-1:0]   brk_cnt, brk_n;
  logic [2:0]         hall_s1, hall_s2, hall_prev;
  logic               hall_edge;
  logic [11:0]        ramp_mag;

  // Two-flop synchronizer plus one history stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hall_s1   <= '0;
      hall_s2   <= '0;
      hall_prev <= '0;
    end else begin
      hall_s1   <= {hallGrn, hallYlw, hallBlu};
      hall_s2   <= hall_s1;
      hall_prev <= hall_s2;
    end
  end

  assign hall_edge = (hall_s2 != hall_prev);

  // One ramp step toward the target, clamped so it never overshoots or wraps.
  always_comb begin
    ramp_mag = drv_mag;
    if (target_mag > drv_mag) begin
      if ((target_mag - drv_mag) > STEP) ramp_mag = drv_mag + STEP;
      else                                ramp_mag = target_mag;
    end else if (target_mag < drv_mag) begin
      if ((drv_mag - target_mag) > STEP) ramp_mag = drv_mag - STEP;
      else                                ramp_mag = target_mag;
    end
  end

  always_comb begin
    stall_run = stall_cnt;
    if (hall_edge || (drv_mag < MIN_MAG)) stall_run = '0;
    else if (stall_cnt != STALL_LIMIT)    stall_run = stall_cnt + STALL_ONE;
  end

  always_comb begin
    state_n = state;
    mag_n   = drv_mag;
    div_n   = div_cnt;
    stall_n = stall_cnt;
    brk_n   = brk_cnt;
    case (state)
      IDLE: begin
        mag_n   = '0;
        div_n   = '0;
        stall_n = '0;
        brk_n   = '0;
        if (en && (target_mag != 12'd0)) state_n = RAMP;
      end
      RAMP, RUN: begin
        // Enable drop outranks a stall detected in the same cycle.
        if (!en) begin
          state_n = BRAKE;
          mag_n   = '0;
          brk_n   = '0;
        end else if (stall_run == STALL_LIMIT) begin
          state_n = FAULT;
          mag_n   = '0;
          stall_n = stall_run;
        end else begin
          stall_n = stall_run;
          if (state == RAMP) begin
            if (div_cnt == DIV_LAST) begin
              div_n = '0;
              mag_n = ramp_mag;
              if (ramp_mag == target_mag) state_n = RUN;
            end else begin
              div_n = div_cnt + DIV_ONE;
            end
          end else if (target_mag != drv_mag) begin
            state_n = RAMP;
            div_n   = '0;
          end
        end
      end
      BRAKE: begin
        mag_n = '0;
        if (brk_cnt == BRK_LAST) state_n = IDLE;
        else                     brk_n   = brk_cnt + BRK_ONE;
      end
      FAULT: begin
        mag_n = '0;
        if (clr_fault && !en) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      drv_mag     <= '0;
      div_cnt     <= '0;
      stall_cnt   <= '0;
      brk_cnt     <= '0;
      brake_n     <= 1'b1;
      running     <= 1'b0;
      stall_fault <= 1'b0;
    end else begin
      state       <= state_n;
      drv_mag     <= mag_n;
      div_cnt     <= div_n;
      stall_cnt   <= stall_n;
      brk_cnt     <= brk_n;
      brake_n     <= (state_n != BRAKE);
      running     <= (state_n == RAMP) || (state_n == RUN);
      stall_fault <= (state_n == FAULT);
    end
  end

endmodule

// File: tb/tb_motor_drive_seq.sv
// Randomized scoreboard bench for motor_drive_seq: a behavioural model predicts
// each cycle's outputs and a separate monitor compares them against the DUT.
module tb_motor_drive_seq;

  localparam int RAMP_STEP     = 16;
  localparam int RAMP_DIV      = 4;
  localparam int STALL_CYCLES  = 100;
  localparam int STALL_MIN_MAG = 64;
  localparam int BRAKE_CYCLES  = 20;

  localparam int M_IDLE  = 0;
  localparam int M_RAMP  = 1;
  localparam int M_RUN   = 2;
  localparam int M_BRAKE = 3;
  localparam int M_FAULT = 4;

  typedef struct packed {
    logic [11:0] mag;
    logic        brake_n;
    logic        running;
    logic        fault;
  } resp_t;

  localparam resp_t RESET_RESP = '{mag: 12'h000, brake_n: 1'b1, running: 1'b0, fault: 1'b0};

  logic        clk = 1'b1;
  logic        rst_n;
  logic        en;
  logic [11:0] target_mag;
  logic        hallGrn, hallYlw, hallBlu;
  logic        clr_fault;
  logic [11:0] drv_mag;
  logic        brake_n, running, stall_fault;
  resp_t       dut_now;

  resp_t      exp_q[$];
  logic [2:0] hall_hist[$];
  logic [2:0] hall_val;
  int vectors     = 0;
  int miscompares = 0;
  int m_mode, m_mag, m_phase, m_quiet, m_brake_left;

  motor_drive_seq #(
    .RAMP_STEP(RAMP_STEP), .RAMP_DIV(RAMP_DIV), .STALL_CYCLES(STALL_CYCLES),
    .STALL_MIN_MAG(STALL_MIN_MAG), .BRAKE_CYCLES(BRAKE_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .target_mag(target_mag),
    .hallGrn(hallGrn), .hallYlw(hallYlw), .hallBlu(hallBlu), .clr_fault(clr_fault),
    .drv_mag(drv_mag), .brake_n(brake_n), .running(running), .stall_fault(stall_fault)
  );

  always #5 clk = ~clk;

  assign dut_now = {drv_mag, brake_n, running, stall_fault};

  function automatic void model_reset();
    m_mode = M_IDLE;
    m_mag = 0;
    m_phase = 0;
    m_quiet = 0;
    m_brake_left = 0;
    hall_hist.delete();
    repeat (3) hall_hist.push_back(3'b000);
  endfunction

  // One clock of the drive rules, with a hall change seen two cycles late.
  function automatic void model_step(input logic e, input int tgt, input logic clr, input logic [2:0] h);
    logic moved;
    int diff;
    hall_hist.push_front(h);
    moved = (hall_hist[2] != hall_hist[3]);
    void'(hall_hist.pop_back());
    if (m_mode == M_IDLE) begin
      m_mag = 0;
      m_phase = 0;
      m_quiet = 0;
      if (e && tgt != 0) m_mode = M_RAMP;
    end else if (m_mode == M_RAMP || m_mode == M_RUN) begin
      if (!e) begin
        m_mode = M_BRAKE;
        m_mag = 0;
        m_brake_left = BRAKE_CYCLES;
      end else begin
        if (moved || m_mag < STALL_MIN_MAG) m_quiet = 0;
        else if (m_quiet < STALL_CYCLES)    m_quiet++;
        if (m_quiet >= STALL_CYCLES) begin
          m_mode = M_FAULT;
          m_mag = 0;
        end else if (m_mode == M_RAMP) begin
          m_phase++;
          if (m_phase == RAMP_DIV) begin
            m_phase = 0;
            diff = tgt - m_mag;
            if (diff > RAMP_STEP)  diff = RAMP_STEP;
            if (diff < -RAMP_STEP) diff = -RAMP_STEP;
            m_mag += diff;
            if (m_mag == tgt) m_mode = M_RUN;
          end
        end else if (tgt != m_mag) begin
          m_mode = M_RAMP;
          m_phase = 0;
        end
      end
    end else if (m_mode == M_BRAKE) begin
      m_brake_left--;
      if (m_brake_left == 0) m_mode = M_IDLE;
    end else begin
      if (clr && !e) m_mode = M_IDLE;
    end
  endfunction

  function automatic resp_t model_outputs();
    resp_t r;
    r.mag     = m_mag[11:0];
    r.brake_n = (m_mode != M_BRAKE);
    r.running = (m_mode == M_RAMP) || (m_mode == M_RUN);
    r.fault   = (m_mode == M_FAULT);
    return r;
  endfunction

  task automatic checkOutput(input string name, input resp_t act, input resp_t req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s @%0t: got mag=%03h brake_n=%b running=%b fault=%b, required mag=%03h brake_n=%b running=%b fault=%b",
               name, $time, act.mag, act.brake_n, act.running, act.fault,
               req.mag, req.brake_n, req.running, req.fault);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [11:0] tgt, input logic clr);
    @(negedge clk);
    rst_n      = 1'b1;
    en         = e;
    target_mag = tgt;
    clr_fault  = clr;
    {hallGrn, hallYlw, hallBlu} = hall_val;
    model_step(e, int'(tgt), clr, hall_val);
    exp_q.push_back(model_outputs());
  endtask

  task automatic holdReset(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      exp_q.push_back(RESET_RESP);
    end
  endtask

  // Reset lands mid-cycle so the immediate (asynchronous) response is observable.
  task automatic pulseReset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1 checkOutput("async_reset", dut_now, RESET_RESP);
    exp_q.push_back(RESET_RESP);
  endtask

  function automatic logic [11:0] pickTarget();
    case ($urandom_range(0, 6))
      0: return 12'h100;
      1: return 12'h105;
      2: return 12'h0F0;
      3: return 12'h030;
      4: return 12'h000;
      5: return 12'hFFF;
      default: return 12'($urandom_range(0, 4095));
    endcase
  endfunction

  task automatic segRotate(input logic [11:0] tgt, input int len, input int period, input bit wander);
    logic [11:0] t;
    t = tgt;
    for (int i = 0; i < len; i++) begin
      if (i % period == period - 1) begin
        int k;
        k = $urandom_range(0, 2);
        hall_val[k] = ~hall_val[k];
      end
      if (wander && $urandom_range(0, 63) == 0) t = pickTarget();
      applyStimulus(1'b1, t, 1'b0);
    end
  endtask

  task automatic segFrozen(input logic [11:0] tgt, input int len);
    for (int i = 0; i < len; i++) applyStimulus(1'b1, tgt, 1'b0);
  endtask

  task automatic segStall(input logic [11:0] tgt);
    segFrozen(tgt, 250);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, tgt, i == 2);
    applyStimulus(1'b0, tgt, 1'b0);
    applyStimulus(1'b0, tgt, 1'b1);
    repeat (3) applyStimulus(1'b0, tgt, 1'b0);
  endtask

  task automatic segBrake(input logic [11:0] tgt, input int reset_at);
    for (int i = 0; i < 40; i++) begin
      if (i == reset_at) pulseReset();
      else               applyStimulus(i >= 5, tgt, 1'b0);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL scoreboard_empty @%0t: got no expectation, required one per cycle", $time);
      end else begin
        checkOutput("cycle", dut_now, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    en         = 1'b0;
    target_mag = '0;
    clr_fault  = 1'b0;
    hall_val   = 3'b001;
    {hallGrn, hallYlw, hallBlu} = hall_val;
    model_reset();
    holdReset(3);

    segRotate(12'h100, 150, 50, 1'b0);
    segRotate(12'h105, 60, 40, 1'b0);
    segRotate(12'h0F0, 40, 40, 1'b0);
    segRotate(12'h100, 40, 40, 1'b0);
    segStall(12'h100);
    segFrozen(12'h030, 300);
    segRotate(12'h100, 100, 30, 1'b0);
    segBrake(12'h100, -1);
    segRotate(12'h200, 40, 30, 1'b0);
    pulseReset();
    segRotate(12'h100, 100, 30, 1'b0);
    segBrake(12'h100, 8);
    segRotate(12'h000, 60, 30, 1'b0);

    for (int s = 0; s < 40; s++) begin
      case ($urandom_range(0, 4))
        0: segRotate(pickTarget(), $urandom_range(80, 300), $urandom_range(20, 60), 1'b1);
        1: segStall(pickTarget());
        2: segBrake(pickTarget(), ($urandom_range(0, 1) == 1) ? $urandom_range(1, 20) : -1);
        3: begin
          segRotate(pickTarget(), $urandom_range(10, 40), 25, 1'b0);
          pulseReset();
        end
        default: segFrozen(12'h030, $urandom_range(100, 250));
      endcase
    end

    @(posedge clk);
    #3;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
